// File: rtl/debug_digit_scanner_pkg.sv
// Shared constants for the debug digit scanner: glyph codes, default geometry
// and the FSM state encoding.
package debug_pkg;

    localparam int DEF_SEQ_LEN    = 16;
    localparam int DEF_SEQ_NUM    = 16;
    localparam int DEF_SEQ_DIGITS = DEF_SEQ_LEN / 4 + 1;

    localparam logic [4:0] GLYPH_PLUS  = 5'd16;
    localparam logic [4:0] GLYPH_MINUS = 5'd17;
    localparam logic [4:0] GLYPH_BLANK = 5'd31;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_SWAP = 2'd2;

endpackage

// File: rtl/hex_digit_sel.sv
// Combinational glyph picker: index 0 is the sign, 1..N are magnitude nibbles
// MSB first. Negative values are shown as sign plus two's-complement magnitude.
module hex_digit_sel
    import debug_pkg::*;
#(
    parameter int SEQ_LEN = DEF_SEQ_LEN
) (
    input  logic [SEQ_LEN-1:0] value,
    input  logic [2:0]         dig_idx,
    output logic [4:0]         code
);

    localparam int NIB = SEQ_LEN / 4;

    logic [SEQ_LEN-1:0] mag;

    always_comb begin
        // Unsigned negation: the most negative value maps onto itself.
        mag  = value[SEQ_LEN-1] ? (SEQ_LEN'(0) - value) : value;
        code = GLYPH_BLANK;
        if (dig_idx == 3'd0) begin
            code = value[SEQ_LEN-1] ? GLYPH_MINUS : GLYPH_PLUS;
        end else begin
            for (int i = 0; i < NIB; i++) begin
                if (dig_idx == 3'(NIB - i))
                    code = {1'b0, mag[i*4 +: 4]};
            end
        end
    end

endmodule

// File: rtl/debug_digit_scanner.sv
// Snapshots debug sequences at vertical blank, renders them one glyph per cycle
// into a back buffer, then swaps it to the front for the pixel generator.
module debug_digit_scanner
    import debug_pkg::*;
#(
    parameter int SEQ_LEN    = DEF_SEQ_LEN,
    parameter int SEQ_NUM    = DEF_SEQ_NUM,
    parameter int SEQ_DIGITS = SEQ_LEN / 4 + 1
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       frame_start,
    input  logic [SEQ_NUM*SEQ_LEN-1:0] seq_in,
    input  logic [3:0]                 rd_seq,
    input  logic [2:0]                 rd_digit,
    output logic [4:0]                 rd_code,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 overrun_cnt
);

    localparam logic [3:0] SEQ_LAST = 4'(SEQ_NUM - 1);
    localparam logic [2:0] DIG_LAST = 3'(SEQ_DIGITS - 1);

    logic [1:0]                              state;
    logic                                    front;
    logic [3:0]                              seq_idx;
    logic [2:0]                              dig_idx;
    logic [SEQ_NUM-1:0][SEQ_LEN-1:0]         snap;
    logic [1:0][SEQ_NUM-1:0][SEQ_DIGITS-1:0][4:0] glyphs;
    logic [4:0]                              glyph;
    logic                                    rd_oob;

    hex_digit_sel #(.SEQ_LEN(SEQ_LEN)) u_sel (
        .value   (snap[seq_idx]),
        .dig_idx (dig_idx),
        .code    (glyph)
    );

    assign busy   = (state != ST_IDLE);
    assign rd_oob = (32'(rd_seq) >= SEQ_NUM) || (32'(rd_digit) >= SEQ_DIGITS);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            front       <= 1'b0;
            done        <= 1'b0;
            overrun_cnt <= '0;
            rd_code     <= '0;
            seq_idx     <= '0;
            dig_idx     <= '0;
            snap        <= '0;
            glyphs      <= '0;
        end else begin
            done    <= 1'b0;
            // Reads only ever see the front half, so they are safe in any state.
            rd_code <= rd_oob ? GLYPH_BLANK : glyphs[front][rd_seq][rd_digit];

            if (frame_start && busy && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        snap    <= seq_in;
                        seq_idx <= '0;
                        dig_idx <= '0;
                        state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    glyphs[~front][seq_idx][dig_idx] <= glyph;
                    if (dig_idx == DIG_LAST) begin
                        dig_idx <= '0;
                        if (seq_idx == SEQ_LAST) state   <= ST_SWAP;
                        else                     seq_idx <= seq_idx + 4'd1;
                    end else begin
                        dig_idx <= dig_idx + 3'd1;
                    end
                end
                ST_SWAP: begin
                    front <= ~front;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_digit_scanner.sv
// Directed bench for debug_digit_scanner: conversion contents, done timing,
// overrun counting, snapshot isolation and mid-conversion reset.
module tb_debug_digit_scanner;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         frame_start;
    logic [255:0] seq_in;
    logic [3:0]   rd_seq;
    logic [2:0]   rd_digit;
    logic [4:0]   rd_code;
    logic         busy;
    logic         done;
    logic [7:0]   overrun_cnt;

    int errors = 0;
    int checks = 0;

    debug_digit_scanner dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .frame_start (frame_start),
        .seq_in      (seq_in),
        .rd_seq      (rd_seq),
        .rd_digit    (rd_digit),
        .rd_code     (rd_code),
        .busy        (busy),
        .done        (done),
        .overrun_cnt (overrun_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic rd(input int s, input int d, input int exp, input string tag);
        rd_seq   = 4'(s);
        rd_digit = 3'(d);
        step();
        check($sformatf("%s[%0d][%0d]", tag, s, d), int'(rd_code), exp);
    endtask

    task automatic set_seq(input int k, input logic [15:0] v);
        seq_in[k*16 +: 16] = v;
    endtask

    int exp_tab [5][5];
    int tab_seq [5];
    int n, first_done, done_cnt, busy_bad;

    initial begin
        sys_rst = 1'b1; frame_start = 1'b0; seq_in = '0; rd_seq = '0; rd_digit = '0;
        step(); step();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ovr", int'(overrun_cnt), 0);
        check("rst_rd", int'(rd_code), 0);
        sys_rst = 1'b0;

        // Before any conversion: zeros in range, blank out of range.
        rd(0, 0, 0, "pre");
        rd(7, 4, 0, "pre");
        rd(3, 6, 31, "oob");
        rd(0, 5, 31, "oob");
        rd(15, 7, 31, "oob");

        set_seq(0, 16'hFFFF); set_seq(1, 16'h8000); set_seq(2, 16'h1234);
        set_seq(3, 16'h7FFF); set_seq(15, 16'h00A5);
        tab_seq = '{0, 1, 2, 3, 15};
        exp_tab = '{'{17, 0, 0, 0, 1}, '{17, 8, 0, 0, 0}, '{16, 1, 2, 3, 4},
                    '{16, 7, 15, 15, 15}, '{16, 0, 0, 10, 5}};

        // Frame 1: count edges to done, front buffer must stay zero meanwhile.
        rd_seq = 4'd0; rd_digit = 3'd4;
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check("f1_busy_start", int'(busy), 1);
        n = 0; first_done = 0; busy_bad = 0;
        while (first_done == 0 && n < 200) begin
            step(); n++;
            if (done) first_done = n;
            else begin
                if (!busy) busy_bad++;
                if (rd_code !== 5'd0) busy_bad++;
            end
        end
        check("f1_done_edge", first_done, 81);
        check("f1_busy_front_bad", busy_bad, 0);
        check("f1_rd_at_done", int'(rd_code), 0);
        step();
        check("f1_done_pulse", int'(done), 0);
        check("f1_rd_after_done", int'(rd_code), 1);
        for (int i = 0; i < 5; i++)
            for (int d = 0; d < 5; d++) rd(tab_seq[i], d, exp_tab[i][d], "f1");
        rd(5, 0, 16, "f1");
        rd(3, 6, 31, "f1_oob");

        // Frame 2: late seq_in change and extra frame_start must not disturb it.
        frame_start = 1'b1; step(); frame_start = 1'b0;
        first_done = 0; done_cnt = 0;
        for (int c = 1; c <= 150; c++) begin
            if (c == 10) set_seq(2, 16'h0001);
            frame_start = (c == 20);
            step();
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = c;
            end
        end
        frame_start = 1'b0;
        check("f2_done_edge", first_done, 81);
        check("f2_done_cnt", done_cnt, 1);
        check("f2_ovr", int'(overrun_cnt), 1);
        for (int d = 0; d < 5; d++) rd(2, d, exp_tab[2][d], "f2");

        // Frame 3: reset at cycle 40 of conversion.
        frame_start = 1'b1; step(); frame_start = 1'b0;
        for (int c = 1; c < 40; c++) step();
        sys_rst = 1'b1; step(); sys_rst = 1'b0;
        check("f3_busy", int'(busy), 0);
        check("f3_ovr", int'(overrun_cnt), 0);
        check("f3_done", int'(done), 0);
        done_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (done) done_cnt++;
        end
        check("f3_no_done", done_cnt, 0);
        rd(0, 0, 0, "f3");
        rd(2, 4, 0, "f3");
        rd(15, 3, 0, "f3");

        // frame_start with reset asserted is ignored.
        sys_rst = 1'b1; frame_start = 1'b1; step();
        sys_rst = 1'b0; frame_start = 1'b0; step();
        check("rst_fs_busy", int'(busy), 0);

        // Held frame_start: back-to-back frames, overrun saturates.
        frame_start = 1'b1;
        for (int c = 0; c < 400; c++) step();
        frame_start = 1'b0;
        check("ovr_sat", int'(overrun_cnt), 255);
        n = 0;
        while (busy && n < 200) begin step(); n++; end
        check("ovr_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_digit_scanner.md
DEBUG_DIGIT_SCANNER -- requirements
Module: debug_digit_scanner

Interface
REQ-001 SEQ_LEN, default 16, width in bits of each debug sequence (multiple of 4).
REQ-002 SEQ_NUM, default 16, number of debug sequences.
REQ-003 SEQ_DIGITS, default SEQ_LEN/4+1, glyphs per sequence: 1 sign plus SEQ_LEN/4 hex digits.
REQ-004 sys_clk  in  1  sole clock, all logic on rising edge.
REQ-005 sys_rst  in  1  reset, synchronous and active-high.
REQ-006 frame_start  in  1  one-cycle pulse at the start of vertical blank.
REQ-007 seq_in  in  SEQ_NUM*SEQ_LEN  flattened sign-padded sequences; sequence k occupies bits [k*SEQ_LEN +: SEQ_LEN].
REQ-008 rd_seq  in  4  read sequence index from the pixel generator.
REQ-009 rd_digit  in  3  read glyph index, 0 = sign, 1..4 = hex digits MSB first.
REQ-010 rd_code  out  5  glyph code: 0-15 hex value, 16 '+', 17 '-', 31 blank.
REQ-011 busy  out  1  high while a conversion is in progress.
REQ-012 done  out  1  one-cycle pulse when a new frame of glyphs becomes visible.
REQ-013 overrun_cnt  out  8  count of frame_start pulses dropped while busy.

Function
REQ-014 States: IDLE, CONV, SWAP; busy = (state != IDLE).
REQ-015 IDLE, frame_start=1: load all of seq_in into a snapshot register, clear seq_idx and dig_idx, go to CONV.
REQ-016 CONV: write exactly one glyph per cycle into the back buffer at [seq_idx][dig_idx]; dig_idx runs 0..SEQ_DIGITS-1, then seq_idx increments.
REQ-017 Sign glyph: 17 if the snapshot MSB is 1, otherwise 16.
REQ-018 Hex glyphs come from the magnitude: the snapshot value, or its two's-complement negation if negative; the negation uses SEQ_LEN-bit unsigned arithmetic, so 16'h8000 yields magnitude 16'h8000.
REQ-019 After the write of [SEQ_NUM-1][SEQ_DIGITS-1], go to SWAP.
REQ-020 SWAP lasts one cycle; toggle the front/back select, assert done, return to IDLE.
REQ-021 done rises on the clock edge SEQ_NUM*SEQ_DIGITS+1 edges after the edge that sampled frame_start (81 for the defaults).
REQ-022 frame_start in CONV or SWAP is ignored; overrun_cnt increments and saturates at 255.
REQ-023 seq_in changes after the snapshot edge have no effect on the current conversion.
REQ-024 rd_code is registered from the front buffer; latency is 1 cycle from rd_seq/rd_digit to rd_code.
REQ-025 Reads are legal in every state and never observe the back buffer.
REQ-026 rd_seq >= SEQ_NUM or rd_digit >= SEQ_DIGITS returns 31 on the next cycle.

Reset
REQ-027 sys_rst=1 at a clock edge forces: state=IDLE, busy=0, done=0, overrun_cnt=0, rd_code=0, front select=0, all glyphs of both buffers=0, seq_idx=dig_idx=0.
REQ-028 Reset mid-CONV abandons the conversion; no SWAP occurs, and the front buffer reads all zero.
REQ-029 A frame_start coincident with sys_rst=1 is ignored.

Structure
REQ-030 A shared package debug_pkg holds the glyph constants (GLYPH_PLUS=16, GLYPH_MINUS=17, GLYPH_BLANK=31), the default SEQ_LEN/SEQ_NUM/SEQ_DIGITS, and the scanner state encoding.
REQ-031 One sub-module, hex_digit_sel, maps (value, dig_idx) to a glyph code combinationally; the FSM, buffers and read port stay in debug_digit_scanner.

Verification
REQ-032 seq0=16'hFFFF, frame_start -> after done, reads of seq0 digits 0..4 give 17,0,0,0,1.
REQ-033 seq1=16'h8000, seq2=16'h1234 -> seq1 gives 17,8,0,0,0; seq2 gives 16,1,2,3,4; done appears exactly 81 edges after frame_start, with busy high throughout.
REQ-034 Change seq2 to 16'h0001 at cycle 10 of CONV; send a second frame_start at cycle 20 -> seq2 still gives 16,1,2,3,4, overrun_cnt=1, no extra done.
REQ-035 Before the first done, read any index -> 0; read rd_seq=3, rd_digit=6 -> 31 one cycle later; values change only in the cycle after done.
REQ-036 Assert sys_rst at cycle 40 of CONV -> next cycle busy=0, overrun_cnt=0, all reads 0, no done pulse.
